// File: rtl/logc_arbiter.sv
// Round-robin arbiter feeding one shared log-compression pipeline.
// Stages one sample at a time and tags every in-flight sample with its source channel.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ch_en, req_*        : per-channel enable mask and valid/ready/data requests
//   pipe_in_*, pipe_data: staged sample toward the compression pipeline
//   pipe_out_*, pipe_comp: compressed result coming back from the pipeline
//   rsp_*               : tagged compressed result toward downstream
//   inflight            : tag FIFO occupancy
//   err_underflow       : sticky, result seen while no sample was in flight
//   stat_cnt            : per-channel 16-bit saturating completion counters
//
// Optional feature: define LOGC_ARB_STATS_EN to build the completion counters;
// otherwise stat_cnt is constant zero.

module logc_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 48,
    parameter int COMP_WIDTH = DATA_WIDTH / 2,
    parameter int TAG_DEPTH  = 8,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]            req_ready,
    output logic                         pipe_in_valid,
    input  logic                         pipe_in_ready,
    output logic [DATA_WIDTH-1:0]        pipe_data,
    input  logic                         pipe_out_valid,
    output logic                         pipe_out_ready,
    input  logic [COMP_WIDTH-1:0]        pipe_comp,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [CH_W-1:0]              rsp_ch,
    output logic [COMP_WIDTH-1:0]        rsp_data,
    output logic [$clog2(TAG_DEPTH):0]   inflight,
    output logic                         err_underflow,
    output logic [NUM_CH*16-1:0]         stat_cnt
);

    localparam int PW = $clog2(TAG_DEPTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_e;

    stage_e                state;
    logic [CH_W-1:0]       rr_ptr;
    logic [NUM_CH-1:0]     eligible;
    logic [CH_W-1:0]       grant_idx;
    logic                  found;
    int                    j;
    logic                  load;
    logic                  hs_out;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic [CH_W-1:0]       tag_mem [TAG_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;

    assign eligible   = req_valid & ch_en;
    assign fifo_full  = (count == (PW+1)'(TAG_DEPTH));
    assign fifo_empty = (count == '0);

    // First eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = (int'(rr_ptr) + i) % NUM_CH;
            if (!found && eligible[j]) begin
                found     = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
    end

    // Space is judged on current occupancy only; a same-cycle pop does not count.
    assign load = ((state == EMPTY) || pipe_in_ready) && !fifo_full && found;

    always_comb begin
        req_ready = '0;
        if (load)
            req_ready[grant_idx] = 1'b1;
    end

    assign pipe_in_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            pipe_data <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            state     <= FULL;
            pipe_data <= req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr    <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
        end else if (state == FULL && pipe_in_ready) begin
            state     <= EMPTY;
        end
    end

    // Response path is a straight pass-through.
    assign pipe_out_ready = rsp_ready;
    assign rsp_valid      = pipe_out_valid;
    assign rsp_data       = pipe_comp;
    assign hs_out         = pipe_out_valid && rsp_ready;
    assign pop            = hs_out && !fifo_empty;
    assign rsp_ch         = fifo_empty ? '0 : tag_mem[rd_ptr];
    assign inflight       = count;

    always_ff @(posedge clk) begin
        if (load)
            tag_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (load)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({load, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (hs_out && fifo_empty)
                err_underflow <= 1'b1;
        end
    end

`ifdef LOGC_ARB_STATS_EN
    logic [15:0] stat_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++)
                stat_q[k] <= '0;
        end else if (pop && stat_q[rsp_ch] != 16'hFFFF) begin
            stat_q[rsp_ch] <= stat_q[rsp_ch] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign stat_cnt[g*16 +: 16] = stat_q[g];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
